// File: rtl/safe_lock_fsm.sv
// rtl/safe_lock_fsm.sv - combination-lock checker: stride-scattered symbol store, rotated key compare, lockout
module safe_lock_fsm #(
  parameter int                       SYM_W       = 7,
  parameter int                       DEPTH       = 8,
  parameter int                       STRIDE      = 5,
  parameter int                       ROT         = 0,
  parameter logic [DEPTH*SYM_W-1:0]   KEY         = '0,
  parameter int                       MAX_FAILS   = 3,
  parameter int                       LOCK_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [SYM_W-1:0]                 data,
  input  logic                             abort,
  input  logic                             relock,
  output logic                             open_safe,
  output logic                             fail,
  output logic                             locked,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fails,
  output logic [DEPTH*SYM_W-1:0]           mem_word,
  output logic [DEPTH*SYM_W-1:0]           exp_word
);

  localparam int KEY_W = DEPTH * SYM_W;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int FW    = $clog2(MAX_FAILS + 1);
  localparam int TW    = $clog2(LOCK_CYCLES + 1);

  localparam logic [IDX_W-1:0] STRIDE_M   = IDX_W'(STRIDE % DEPTH);
  localparam logic [IDX_W-1:0] LAST_CNT   = IDX_W'(DEPTH - 1);
  localparam logic [FW-1:0]    FAILS_MAX  = FW'(MAX_FAILS);
  localparam logic [FW-1:0]    FAILS_LAST = FW'(MAX_FAILS - 1);
  localparam logic [TW-1:0]    TIMER_INIT = TW'(LOCK_CYCLES);

  if ((STRIDE % 2) == 0) begin : g_bad_stride
    $error("safe_lock_fsm: STRIDE must be odd");
  end
  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("safe_lock_fsm: DEPTH must be a power of 2 and at least 2");
  end
  if ((MAX_FAILS < 1) || (LOCK_CYCLES < 1)) begin : g_bad_limits
    $error("safe_lock_fsm: MAX_FAILS and LOCK_CYCLES must be at least 1");
  end
  if ((ROT < 0) || (ROT >= KEY_W)) begin : g_bad_rot
    $error("safe_lock_fsm: ROT out of range");
  end

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CHECK   = 2'd1,
    S_OPEN    = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t              state, state_d;
  logic [IDX_W-1:0]    idx, idx_d;
  logic [IDX_W-1:0]    cnt, cnt_d;
  logic [FW-1:0]       fails_d;
  logic [TW-1:0]       timer, timer_d;
  logic                fail_d;
  logic                wr_en;
  logic [SYM_W-1:0]    mem [DEPTH];
  logic [KEY_W-1:0]    rot_word;
  logic                key_match;

  for (genvar g = 0; g < DEPTH; g++) begin : g_pack
    assign mem_word[g*SYM_W +: SYM_W] = mem[g];
  end

  always_comb begin
    rot_word = '0;
    for (int i = 0; i < KEY_W; i++) begin
      rot_word[(i + ROT) % KEY_W] = mem_word[i];
    end
  end

  assign key_match = (rot_word == KEY);
  assign exp_word  = KEY;
  assign open_safe = (state == S_OPEN);
  assign locked    = (state == S_LOCKED);

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    cnt_d    = cnt;
    fails_d  = fails;
    timer_d  = timer;
    fail_d   = 1'b0;
    wr_en    = 1'b0;
    in_ready = 1'b0;
    case (state)
      S_COLLECT: begin
        in_ready = 1'b1;
        // abort wins over a same-cycle accept; stored symbols are left in place
        if (abort) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (in_valid) begin
          wr_en = 1'b1;
          idx_d = idx + STRIDE_M;
          cnt_d = cnt + IDX_W'(1);
          if (cnt == LAST_CNT) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        idx_d = '0;
        cnt_d = '0;
        if (key_match) begin
          state_d = S_OPEN;
          fails_d = '0;
        end else if (fails == FAILS_LAST) begin
          fails_d = FAILS_MAX;
          fail_d  = 1'b1;
          timer_d = TIMER_INIT;
          state_d = S_LOCKED;
        end else begin
          fails_d = fails + FW'(1);
          fail_d  = 1'b1;
          state_d = S_COLLECT;
        end
      end
      S_OPEN: begin
        if (relock) state_d = S_COLLECT;
      end
      S_LOCKED: begin
        timer_d = timer - TW'(1);
        if (timer == TW'(1)) begin
          state_d = S_COLLECT;
          fails_d = '0;
        end
      end
      default: state_d = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_COLLECT;
      idx   <= '0;
      cnt   <= '0;
      fails <= '0;
      timer <= '0;
      fail  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      fails <= fails_d;
      timer <= timer_d;
      fail  <= fail_d;
      if (wr_en) mem[idx] <= data;
    end
  end

endmodule

// File: tb/tb_safe_lock_fsm.sv
// tb/tb_safe_lock_fsm.sv - directed self-checking bench for safe_lock_fsm
module tb_safe_lock_fsm;

  localparam logic [55:0] KEY0 = {7'h17, 7'h16, 7'h15, 7'h14, 7'h13, 7'h12, 7'h11, 7'h10};
  localparam logic [55:0] KEY_R3 = {KEY0[52:0], KEY0[55:53]};

  logic clk = 1'b0;
  logic rst_n, in_valid, abort, relock;
  logic [6:0] data;

  logic in_ready, open_safe, fail, locked;
  logic [1:0] fails;
  logic [55:0] mem_word, exp_word;

  logic r3_in_ready, r3_open, r3_fail, r3_locked;
  logic [1:0] r3_fails;
  logic [55:0] r3_mem, r3_exp;

  logic r0_in_ready, r0_open, r0_fail, r0_locked;
  logic [1:0] r0_fails;
  logic [55:0] r0_mem, r0_exp;

  logic [6:0] good [8] = '{7'h10, 7'h15, 7'h12, 7'h17, 7'h14, 7'h11, 7'h16, 7'h13};
  logic [55:0] wrong_word;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  safe_lock_fsm #(.KEY(KEY0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data(data),
    .abort(abort), .relock(relock), .open_safe(open_safe), .fail(fail), .locked(locked),
    .fails(fails), .mem_word(mem_word), .exp_word(exp_word)
  );

  safe_lock_fsm #(.ROT(3), .KEY(KEY_R3)) u_rot3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r3_in_ready), .data(data),
    .abort(abort), .relock(relock), .open_safe(r3_open), .fail(r3_fail), .locked(r3_locked),
    .fails(r3_fails), .mem_word(r3_mem), .exp_word(r3_exp)
  );

  safe_lock_fsm #(.ROT(0), .KEY(KEY_R3)) u_rot0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r0_in_ready), .data(data),
    .abort(abort), .relock(relock), .open_safe(r0_open), .fail(r0_fail), .locked(r0_locked),
    .fails(r0_fails), .mem_word(r0_mem), .exp_word(r0_exp)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] sym);
    in_valid = 1'b1;
    data     = sym;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_seq(input bit bad);
    for (int i = 0; i < 8; i++) send((bad && i == 7) ? 7'h00 : good[i]);
  endtask

  task automatic do_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_open"}, open_safe, 1'b0);
    check({tag, "_fail"}, fail, 1'b0);
    check({tag, "_locked"}, locked, 1'b0);
    check({tag, "_fails"}, fails, 2'd0);
    check({tag, "_mem"}, mem_word, 56'd0);
  endtask

  initial begin
    int lock_len;
    int bad_ready;
    logic [55:0] mem_before;

    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; relock = 1'b0; data = '0;
    wrong_word = KEY0;
    wrong_word[27:21] = 7'h00;
    tick();
    tick();
    check_reset_outputs("reset");
    check("exp_word", exp_word, KEY0);
    rst_n = 1'b1;

    // correct entry opens, relock returns to collect
    send_seq(1'b0);
    check("check_in_ready", in_ready, 1'b0);
    check("check_open_early", open_safe, 1'b0);
    tick();
    check("open", open_safe, 1'b1);
    check("open_in_ready", in_ready, 1'b0);
    check("open_fail", fail, 1'b0);
    check("open_mem", mem_word, KEY0);
    do_relock();
    check("relock_open", open_safe, 1'b0);
    check("relock_in_ready", in_ready, 1'b1);

    // single wrong attempt, then immediate correct attempt
    send_seq(1'b1);
    tick();
    check("wrong_fail", fail, 1'b1);
    check("wrong_fails", fails, 2'd1);
    check("wrong_in_ready", in_ready, 1'b1);
    check("wrong_locked", locked, 1'b0);
    check("wrong_mem", mem_word, wrong_word);
    send(good[0]);
    check("fail_one_cycle", fail, 1'b0);
    for (int i = 1; i < 8; i++) send(good[i]);
    tick();
    check("retry_open", open_safe, 1'b1);
    check("retry_fails", fails, 2'd0);
    do_relock();

    // three wrong attempts lock the safe
    send_seq(1'b1); tick();
    check("lk_fails1", fails, 2'd1);
    send_seq(1'b1); tick();
    check("lk_fails2", fails, 2'd2);
    send_seq(1'b1); tick();
    check("lk_fail3", fail, 1'b1);
    check("lk_locked", locked, 1'b1);
    check("lk_fails3", fails, 2'd3);
    check("lk_in_ready", in_ready, 1'b0);
    lock_len = 1;
    bad_ready = 0;
    mem_before = mem_word;
    in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      data = 7'($urandom);
      tick();
      if (!locked) break;
      lock_len++;
      if (in_ready) bad_ready++;
    end
    in_valid = 1'b0;
    check("lk_len", lock_len, 16);
    check("lk_ready_low", bad_ready, 0);
    check("lk_mem_kept", mem_word, mem_before);
    check("lk_after_ready", in_ready, 1'b1);
    check("lk_after_fails", fails, 2'd0);
    send_seq(1'b0); tick();
    check("lk_after_open", open_safe, 1'b1);
    do_relock();

    // abort drops the same-cycle symbol and restarts the index
    for (int i = 0; i < 3; i++) send(good[i]);
    abort = 1'b1; in_valid = 1'b1; data = 7'h55;
    tick();
    abort = 1'b0; in_valid = 1'b0;
    check("abort_slot7", mem_word[55:49], 7'h17);
    send_seq(1'b0); tick();
    check("abort_open", open_safe, 1'b1);
    do_relock();

    // gapped valid
    for (int i = 0; i < 8; i++) begin
      while ($urandom_range(1, 0) == 0) tick();
      send(good[i]);
    end
    tick();
    check("gap_open", open_safe, 1'b1);
    do_relock();

    // reset mid-attempt, during LOCKED, during OPEN
    for (int i = 0; i < 5; i++) send(good[i]);
    do_reset();
    check_reset_outputs("rst_mid");
    for (int a = 0; a < 3; a++) begin
      send_seq(1'b1); tick();
    end
    tick(); tick();
    check("rst_lk_pre", locked, 1'b1);
    do_reset();
    check_reset_outputs("rst_lk");
    send_seq(1'b0); tick();
    check("rst_open_pre", open_safe, 1'b1);
    do_reset();
    check_reset_outputs("rst_open");

    // rotated compare
    send_seq(1'b0); tick();
    check("rot3_open", r3_open, 1'b1);
    check("rot0_fail", r0_fail, 1'b1);
    check("rot0_open", r0_open, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
